// File: rtl/puf_axi4l_pkg.sv
// rtl/puf_axi4l_pkg.sv - register map, response codes and bit indices shared by the PUF AXI4-Lite slave
package puf_axi4l_pkg;

    // Register indices as selected by address bits [3:2]
    localparam logic [1:0] REG_CTRL      = 2'd0;
    localparam logic [1:0] REG_CHALLENGE = 2'd1;
    localparam logic [1:0] REG_RESPONSE  = 2'd2;
    localparam logic [1:0] REG_STATUS    = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;
    localparam int CTRL_START_BIT  = 0;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/puf_axi4l_wr_join.sv
// rtl/puf_axi4l_wr_join.sv - AW/W one-entry holding registers, write join and B-channel handshake
module puf_axi4l_wr_join
    import puf_axi4l_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    output logic                  commit,
    output logic [ADDR_WIDTH-1:0] commit_addr,
    output logic [31:0]           commit_data,
    output logic [3:0]            commit_strb,
    input  logic [1:0]            commit_resp
);

    logic aw_held;
    logic w_held;

    // Both channels stall while a response is outstanding so at most one write is in flight
    assign awready = !reset && !aw_held && !bvalid;
    assign wready  = !reset && !w_held && !bvalid;
    assign commit  = aw_held && w_held && !bvalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            commit_addr <= '0;
            commit_data <= '0;
            commit_strb <= '0;
            bvalid      <= 1'b0;
            bresp       <= RESP_OKAY;
        end else begin
            if (awvalid && awready) begin
                aw_held     <= 1'b1;
                commit_addr <= awaddr;
            end
            if (wvalid && wready) begin
                w_held      <= 1'b1;
                commit_data <= wdata;
                commit_strb <= wstrb;
            end
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= commit_resp;
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
                bresp  <= RESP_OKAY;
            end
        end
    end

endmodule

// File: rtl/puf_axi4l_slave.sv
// rtl/puf_axi4l_slave.sv - AXI4-Lite register front end for the ring-oscillator PUF core
// Define PUF_AXI_WR_SLVERR_EN to answer writes to RESPONSE with SLVERR instead of OKAY.
module puf_axi4l_slave
    import puf_axi4l_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            puf_start,
    output logic [31:0]                     puf_challenge,
    input  logic [31:0]                     puf_resp,
    input  logic                            puf_done
);

    logic                          wr_commit;
    logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]                   wr_data;
    logic [3:0]                    wr_strb;
    logic [1:0]                    wr_resp;
    logic [1:0]                    wr_idx;

    logic [31:0] ctrl_q;
    logic [31:0] ctrl_next;
    logic [31:0] challenge_q;
    logic [31:0] response_q;
    logic        busy_q;
    logic        done_q;
    logic        start_q;
    logic        start_req;
    logic        clr_done;

    logic        ar_held;
    logic [1:0]  ar_idx;
    logic [31:0] rd_mux;

    logic unused_ok;
    assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], wr_addr[1:0]};

    puf_axi4l_wr_join #(
        .ADDR_WIDTH (C_S_AXI_ADDR_WIDTH)
    ) u_wr_join (
        .clk         (ACLK),
        .reset       (ARESET),
        .awaddr      (S_AXI_AWADDR),
        .awvalid     (S_AXI_AWVALID),
        .awready     (S_AXI_AWREADY),
        .wdata       (S_AXI_WDATA),
        .wstrb       (S_AXI_WSTRB),
        .wvalid      (S_AXI_WVALID),
        .wready      (S_AXI_WREADY),
        .bresp       (S_AXI_BRESP),
        .bvalid      (S_AXI_BVALID),
        .bready      (S_AXI_BREADY),
        .commit      (wr_commit),
        .commit_addr (wr_addr),
        .commit_data (wr_data),
        .commit_strb (wr_strb),
        .commit_resp (wr_resp)
    );

    assign wr_idx = wr_addr[3:2];

`ifdef PUF_AXI_WR_SLVERR_EN
    assign wr_resp = (wr_idx == REG_RESPONSE) ? RESP_SLVERR : RESP_OKAY;
`else
    assign wr_resp = RESP_OKAY;
`endif

    assign ctrl_next = apply_wstrb(ctrl_q, wr_data, wr_strb);
    assign start_req = wr_commit && (wr_idx == REG_CTRL) && wr_strb[0]
                       && wr_data[CTRL_START_BIT] && !busy_q;
    assign clr_done  = wr_commit && (wr_idx == REG_STATUS) && wr_strb[0]
                       && wr_data[STATUS_DONE_BIT];

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ctrl_q      <= '0;
            challenge_q <= '0;
            response_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            start_q <= start_req;
            // START never persists in the register; it only exists as the pulse
            if (wr_commit && wr_idx == REG_CTRL) ctrl_q <= ctrl_next & 32'hFFFF_FFFE;
            if (wr_commit && wr_idx == REG_CHALLENGE)
                challenge_q <= apply_wstrb(challenge_q, wr_data, wr_strb);
            if (puf_done) response_q <= puf_resp;
            if (start_req)     busy_q <= 1'b1;
            else if (puf_done) busy_q <= 1'b0;
            // A completion arriving with the W1C keeps DONE set
            if (puf_done)      done_q <= 1'b1;
            else if (clr_done) done_q <= 1'b0;
        end
    end

    assign puf_start     = start_q;
    assign puf_challenge = challenge_q;

    always_comb begin
        rd_mux = '0;
        case (ar_idx)
            REG_CTRL:      rd_mux = ctrl_q;
            REG_CHALLENGE: rd_mux = challenge_q;
            REG_RESPONSE:  rd_mux = response_q;
            default:       rd_mux = {30'b0, done_q, busy_q};
        endcase
    end

    // Registers are sampled one edge after the AR handshake, before any write committing on that edge
    assign S_AXI_ARREADY = !ARESET && !ar_held && !S_AXI_RVALID;
    assign S_AXI_RRESP   = RESP_OKAY;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ar_held      <= 1'b0;
            ar_idx       <= '0;
            S_AXI_RDATA  <= '0;
            S_AXI_RVALID <= 1'b0;
        end else begin
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                ar_held <= 1'b1;
                ar_idx  <= S_AXI_ARADDR[3:2];
            end
            if (ar_held) begin
                ar_held      <= 1'b0;
                S_AXI_RDATA  <= rd_mux;
                S_AXI_RVALID <= 1'b1;
            end else if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

endmodule
